// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//   Requesting-side controller for an iterative divider with a start/done
//   handshake. It sits in the execute stage and does the following:
//     - detects DIV/DIVU/REM/REMU;
//     - latches the operands and pulses div_start;
//     - stalls execute until div_done arrives;
//     - returns the result on a registered writeback port.
//   Divide-by-zero is answered locally without touching the divider. A
//   flushed in-flight division is drained (its done pulse is swallowed).
//   After reset a guard window outlasts any division the divider may still
//   be running, because the divider itself has no reset.
//
// Optional build macro: DIV_RESULT_CACHE_EN
//   Adds a one-entry result cache {ctrl, rs1, rs2, result}. It is filled on
//   each divider completion that goes on to writeback. A matching request in
//   IDLE is answered in one cycle with no divider issue.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_valid, ex_is_div     execute holds a valid divide-class instruction
//   ex_div_ctrl             00 DIV, 01 DIVU, 10 REM, 11 REMU
//   ex_rs1, ex_rs2, ex_rd   dividend, divisor, destination register
//   flush                   kill the instruction currently in execute
//   stall                   combinational pipeline hold
//   div_start               one-cycle start pulse to the divider
//   div_ctrl                registered op to the divider
//   div_numerator           registered dividend to the divider
//   div_denominator         registered divisor to the divider
//   div_result, div_done    divider result and one-cycle done pulse
//   wb_valid, wb_rd, wb_data  writeback strobe, register and data
module div_issue_ctrl #(
  parameter int D_WIDTH     = 32,
  parameter int DIV_LATENCY = 35
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic               ex_is_div,
  input  logic [1:0]         ex_div_ctrl,
  input  logic [D_WIDTH-1:0] ex_rs1,
  input  logic [D_WIDTH-1:0] ex_rs2,
  input  logic [4:0]         ex_rd,
  input  logic               flush,
  output logic               stall,
  output logic               div_start,
  output logic [1:0]         div_ctrl,
  output logic [D_WIDTH-1:0] div_numerator,
  output logic [D_WIDTH-1:0] div_denominator,
  input  logic [D_WIDTH-1:0] div_result,
  input  logic               div_done,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [D_WIDTH-1:0] wb_data
);

  typedef enum logic [2:0] {GUARD, IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  localparam int               CNT_W      = $clog2(DIV_LATENCY + 2);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(DIV_LATENCY + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   guard_cnt;
  logic [4:0]         rd_hold;
  logic               req;
  logic               den_zero;
  logic [D_WIDTH-1:0] zero_result;
  logic               cache_hit;
  logic [D_WIDTH-1:0] cache_result;

  assign req      = ex_valid & ex_is_div & ~flush;
  assign den_zero = (ex_rs2 == '0);
  // Division by zero: the quotient is all ones and the remainder is the
  // dividend. ctrl[1] selects REM/REMU.
  assign zero_result = ex_div_ctrl[1] ? ex_rs1 : '1;

`ifdef DIV_RESULT_CACHE_EN
  logic               cache_valid;
  logic [1:0]         cache_ctrl;
  logic [D_WIDTH-1:0] cache_rs1;
  logic [D_WIDTH-1:0] cache_rs2;

  assign cache_hit = cache_valid & (cache_ctrl == ex_div_ctrl) &
                     (cache_rs1 == ex_rs1) & (cache_rs2 == ex_rs2);

  // Only real divider completions that reach writeback fill the cache.
  // Drained results and the local zero-divisor answers never fill it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid  <= 1'b0;
      cache_ctrl   <= '0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_result <= '0;
    end else if (state == WAIT && div_done && !flush) begin
      cache_valid  <= 1'b1;
      cache_ctrl   <= div_ctrl;
      cache_rs1    <= div_numerator;
      cache_rs2    <= div_denominator;
      cache_result <= div_result;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    div_start  = 1'b0;
    wb_valid   = 1'b0;

    stall     = ex_valid & ex_is_div & ~flush & (state != RESP);
    div_start = (state == ISSUE);
    wb_valid  = (state == RESP) & ~flush;

    case (state)
      GUARD: if (guard_cnt == '0) state_next = IDLE;
      IDLE:  if (req) state_next = (den_zero || cache_hit) ? RESP : ISSUE;
      // The start pulse still goes out on a flush. The divider is then
      // busy, so its done pulse must be drained.
      ISSUE: state_next = flush ? DRAIN : WAIT;
      // If done and flush land together, the result is simply dropped.
      // Going to DRAIN here would wait for a done pulse that never comes.
      WAIT: begin
        if (div_done)   state_next = flush ? IDLE : RESP;
        else if (flush) state_next = DRAIN;
      end
      RESP:  state_next = IDLE;
      DRAIN: if (div_done) state_next = IDLE;
      default: state_next = GUARD;
    endcase
  end

  // State, guard counter, divider operands and writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= GUARD;
      guard_cnt       <= GUARD_LOAD;
      div_ctrl        <= '0;
      div_numerator   <= '0;
      div_denominator <= '0;
      rd_hold         <= '0;
      wb_rd           <= '0;
      wb_data         <= '0;
    end else begin
      state <= state_next;

      if (state == GUARD && guard_cnt != '0)
        guard_cnt <= guard_cnt - CNT_W'(1);

      // Operands only change in IDLE. They therefore stay stable from ISSUE
      // through the done pulse, covering both early and late sampling by
      // the divider.
      if (state == IDLE && req) begin
        div_ctrl        <= ex_div_ctrl;
        div_numerator   <= ex_rs1;
        div_denominator <= ex_rs2;
        rd_hold         <= ex_rd;
        if (den_zero) begin
          wb_data <= zero_result;
          wb_rd   <= ex_rd;
        end else if (cache_hit) begin
          wb_data <= cache_result;
          wb_rd   <= ex_rd;
        end
      end

      if (state == WAIT && div_done) begin
        wb_data <= div_result;
        wb_rd   <= rd_hold;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl, with a behavioural latency-accurate divider.
module tb_div_issue_ctrl;

  localparam int DW  = 32;
  localparam int LAT = 35;

`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT   = 1;
  localparam int HIT_START = -1;
`else
  localparam int HIT_LAT   = 37;
  localparam int HIT_START = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid = 1'b0;
  logic          ex_is_div = 1'b0;
  logic [1:0]    ex_div_ctrl = 2'b00;
  logic [DW-1:0] ex_rs1 = '0;
  logic [DW-1:0] ex_rs2 = '0;
  logic [4:0]    ex_rd = '0;
  logic          flush = 1'b0;
  logic          stall;
  logic          div_start;
  logic [1:0]    div_ctrl;
  logic [DW-1:0] div_numerator;
  logic [DW-1:0] div_denominator;
  logic [DW-1:0] div_result = '0;
  logic          div_done = 1'b0;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.D_WIDTH(DW), .DIV_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_is_div(ex_is_div), .ex_div_ctrl(ex_div_ctrl),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
    .stall(stall), .div_start(div_start), .div_ctrl(div_ctrl),
    .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_result(div_result), .div_done(div_done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // Divider model. It has no reset. Operands are taken at start and ctrl at
  // done. The done pulse falls LAT cycles after the start cycle.
  function automatic logic [31:0] model_div(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (b == 32'd0) return 32'hFFFF_FFFF;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (c)
      2'b00:   return 32'(sa / sb);
      2'b01:   return 32'(ua / ub);
      2'b10:   return 32'(sa % sb);
      default: return 32'(ua % ub);
    endcase
  endfunction

  logic          dm_busy = 1'b0;
  int            dm_cnt = 0;
  logic [DW-1:0] dm_a = '0;
  logic [DW-1:0] dm_b = '0;

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (dm_busy) begin
      if (dm_cnt == 1) begin
        div_done   <= 1'b1;
        div_result <= model_div(div_ctrl, dm_a, dm_b);
        dm_busy    <= 1'b0;
      end
      dm_cnt <= dm_cnt - 1;
    end
    if (div_start) begin
      dm_busy <= 1'b1;
      dm_cnt  <= LAT - 1;
      dm_a    <= div_numerator;
      dm_b    <= div_denominator;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one divide and follow it to writeback.
  // The request is first seen in cycle 0; exp_start = -1 means no issue.
  task automatic run_div(input string tag, input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data,
                         input int exp_lat, input int exp_start);
    int n, start_n, starts;
    bit got;
    ex_valid = 1'b1; ex_is_div = 1'b1; ex_div_ctrl = c;
    ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    n = 0; start_n = -1; starts = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (div_start) begin
        starts++;
        if (start_n < 0) start_n = n;
      end
      if (!stall) begin
        got = 1'b1;
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, ".wb_data"}, wb_data, exp_data);
      end
      next_cycle();
      if (!got) n++;
    end
    ex_valid = 1'b0; ex_is_div = 1'b0;
    $display("txn %s ctrl=%0d rs1=%h rs2=%h -> wb_data=%h resp_cycle=%0d start_cycle=%0d",
             tag, c, a, b, wb_data, n, start_n);
    chk({tag, ".resp_cycle"}, 32'(n), 32'(exp_lat));
    chk({tag, ".start_cycle"}, 32'(start_n), 32'(exp_start));
    chk({tag, ".start_count"}, 32'(starts), (exp_start < 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int n, start_n, done_n, stall_low;
    bit got, wb_seen;

    // Reset values
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.div_start", 32'(div_start), 32'd0);
    chk("rst.div_ctrl", 32'(div_ctrl), 32'd0);
    chk("rst.div_numerator", div_numerator, 32'd0);
    chk("rst.div_denominator", div_denominator, 32'd0);
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.wb_rd", 32'(wb_rd), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    repeat (40) next_cycle();

    // Normal divides, the cache pair, and signed cases
    run_div("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 37, 1);
    run_div("divu_100_7_again", 2'b01, 32'd100, 32'd7, 5'd6, 32'd14, HIT_LAT, HIT_START);
    run_div("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd7, 32'd2, 37, 1);
    run_div("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 37, 1);
    run_div("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 37, 1);
    run_div("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 37, 1);

    // Divide by zero is resolved locally
    run_div("div_by0", 2'b00, 32'h8000_0001, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, -1);
    run_div("remu_by0", 2'b11, 32'h0000_1234, 32'd0, 5'd14, 32'h0000_1234, 1, -1);

    // A flush during RESP suppresses wb_valid
    ex_valid = 1'b1; ex_is_div = 1'b1; ex_div_ctrl = 2'b01;
    ex_rs1 = 32'd5; ex_rs2 = 32'd0; ex_rd = 5'd4;
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("resp_flush.wb_valid", 32'(wb_valid), 32'd0);
    $display("txn resp_flush wb_valid=%0d", wb_valid);
    next_cycle();
    flush = 1'b0; ex_valid = 1'b0; ex_is_div = 1'b0;

    // Flush in WAIT: drain, then the next divide issues 2 cycles after the drained done
    ex_valid = 1'b1; ex_is_div = 1'b1; ex_div_ctrl = 2'b01;
    ex_rs1 = 32'd50; ex_rs2 = 32'd5; ex_rd = 5'd7;
    wb_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wb_seen |= wb_valid;
      next_cycle();
    end
    flush = 1'b1;
    @(negedge clk);
    wb_seen |= wb_valid;
    chk("flush.stall", 32'(stall), 32'd0);
    next_cycle();
    flush = 1'b0;
    ex_rs1 = 32'd9; ex_rs2 = 32'd3; ex_rd = 5'd8;
    n = 0; done_n = -1; start_n = -1; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (div_done && done_n < 0) done_n = n;
      if (div_start && start_n < 0) start_n = n;
      if (wb_valid) begin
        got = 1'b1;
        chk("flush.next_wb_data", wb_data, 32'd3);
        chk("flush.next_wb_rd", 32'(wb_rd), 32'd8);
      end
      next_cycle();
      n++;
    end
    ex_valid = 1'b0; ex_is_div = 1'b0;
    $display("txn flush_then_divu_9_3 done_at=%0d start_at=%0d wb_data=%h", done_n, start_n, wb_data);
    chk("flush.wb_suppressed", 32'(wb_seen), 32'd0);
    chk("flush.next_completed", 32'(got), 32'd1);
    chk("flush.issue_gap", 32'(start_n - done_n), 32'd2);

    // Reset in the middle of WAIT, then a divide presented straight away
    ex_valid = 1'b1; ex_is_div = 1'b1; ex_div_ctrl = 2'b01;
    ex_rs1 = 32'd20; ex_rs2 = 32'd4; ex_rd = 5'd3;
    repeat (21) next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.div_start", 32'(div_start), 32'd0);
    chk("midrst.div_numerator", div_numerator, 32'd0);
    chk("midrst.wb_valid", 32'(wb_valid), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    ex_rs1 = 32'd9; ex_rs2 = 32'd3; ex_rd = 5'd9;
    n = 0; start_n = -1; stall_low = 0;
    while (start_n < 0 && n < 100) begin
      @(negedge clk);
      if (div_start) start_n = n;
      else if (!stall || wb_valid) stall_low++;
      next_cycle();
      n++;
    end
    chk("midrst.stall_held", 32'(stall_low), 32'd0);
    chk("midrst.start_not_early", 32'(start_n >= 37), 32'd1);
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (!stall) begin
        got = 1'b1;
        chk("midrst.wb_valid", 32'(wb_valid), 32'd1);
        chk("midrst.wb_data", wb_data, 32'd3);
        chk("midrst.wb_rd", 32'(wb_rd), 32'd9);
      end
      next_cycle();
      if (!got) n++;
    end
    ex_valid = 1'b0; ex_is_div = 1'b0;
    $display("txn midrst_divu_9_3 start_after_release=%0d wb_data=%h", start_n, wb_data);
    chk("midrst.resp_latency", 32'(n), 32'd35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
